// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: start bit, DATA_W data bits (A[0] first), optional even parity, stop bit.
// sout and done are registered; ready/busy decode the registered state.
module serial_frame_tx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [0:DATA_W-1] A,
  input  logic              load,
  output logic              ready,
  output logic              busy,
  output logic              sout,
  output logic              done
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_next;
  logic [BW-1:0]     r_bit_idx;
  logic [BW-1:0]     w_bit_idx_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [DATA_W-1:0] w_a_lsb;
  logic              r_par;
  logic              w_par_next;
  logic              r_sout;
  logic              w_sout_next;
  logic              r_done;
  logic              w_done_next;
  logic              w_bit_end;

  // Re-index the word so bit 0 of the shift register is the first bit on the line.
  always_comb begin
    w_a_lsb = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      w_a_lsb[i] = A[i];
    end
  end

  assign w_bit_end = (r_cnt == CNT_LAST);

  // State register together with the frame datapath; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CW{1'b0}};
      r_bit_idx <= {BW{1'b0}};
      r_shift   <= {DATA_W{1'b0}};
      r_par     <= 1'b0;
      r_sout    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_sout    <= w_sout_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state and datapath update; each non-idle state lasts one full bit period.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_state_next   = ST_START;
          w_cnt_next     = {CW{1'b0}};
          w_bit_idx_next = {BW{1'b0}};
          w_shift_next   = w_a_lsb;
          w_par_next     = even_parity(w_a_lsb);
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = {CW{1'b0}};
          if (r_bit_idx == BIT_LAST) begin
            w_state_next = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + BW'(1);
            w_shift_next   = r_shift >> 1;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_PAR: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = {CW{1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state so sout and done can be registered without lag.
  always_comb begin
    w_sout_next = 1'b1;
    w_done_next = 1'b0;
    case (w_state_next)
      ST_IDLE:  w_sout_next = 1'b1;
      ST_START: w_sout_next = 1'b0;
      ST_DATA:  w_sout_next = w_shift_next[0];
      ST_PAR:   w_sout_next = w_par_next;
      ST_STOP:  w_sout_next = 1'b1;
      default:  w_sout_next = 1'b1;
    endcase
    if ((r_state == ST_STOP) && w_bit_end) begin
      w_done_next = 1'b1;
    end else begin
      w_done_next = 1'b0;
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign busy  = ~ready;
  assign sout  = r_sout;
  assign done  = r_done;

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Transmits a DATA_W-bit parallel word as a framed serial bit stream: start bit, data bits, optional even parity bit, stop bit. It is the transmitting end of the team's 4-bit register path. A word held in a parallel register is handed to this block with a load strobe and leaves on a single line, `sout`. It pairs with a serial-to-parallel receiver that captures the frame back into a register.

## Interface
- DATA_W, default 4: word width in bits, legal range 2–16.
- BIT_CYCLES, default 1: clock cycles each serial bit is held, legal range 1–255.
- PARITY_EN, default 1: when 1, an even-parity bit follows the data; when 0, the parity bit is omitted.

- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset, synchronous and active-high.
- A  in  [0:DATA_W-1]  parallel word. A[0] is transmitted first.
- load  in  1  request to transmit A; accepted only when ready=1.
- ready  out  1  high when idle and able to accept load.
- busy  out  1  high while a frame is in flight (START through STOP).
- sout  out  1  serial line; idles at 1.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- States and their sout values:
  - IDLE: sout=1.
  - START: sout=0.
  - DATA: sout = current data bit.
  - PAR: sout = XOR of all captured data bits (even parity).
  - STOP: sout=1.
- Every state except IDLE lasts exactly BIT_CYCLES cycles.
- Transitions:
  - IDLE→START when load=1 at an edge. A is captured into an internal shift register at that edge.
  - START→DATA.
  - DATA stays in DATA for DATA_W bit periods, shifting one bit per period.
  - DATA→PAR if PARITY_EN=1, otherwise DATA→STOP.
  - PAR→STOP.
  - STOP→IDLE.
- The captured word is frozen for the whole frame. Changes on A after acceptance have no effect.
- load while busy=1 is ignored. It is not queued.
- ready = (state==IDLE), decoded combinationally from registered state. busy = !ready.
- done is registered. It is 1 for exactly the first cycle in IDLE after STOP, and 0 otherwise.
- Parity is computed from the captured word at load time, not from live A.
- Counters:
  - Cycle counter of width clog2(BIT_CYCLES+1); wraps to 0 at the end of each bit period.
  - Bit index of width clog2(DATA_W+1).

## Timing
- Reset: at an edge with clr=1, the next state is:
  - state=IDLE, sout=1, ready=1, busy=0, done=0;
  - shift register, parity, and counters = 0.
- clr has priority over load and over any in-flight frame. A frame aborted mid-bit leaves sout=1 from the next cycle, and no done pulse follows.
- Load latency: load sampled at edge N gives sout=0 (start bit) from edge N through edge N+BIT_CYCLES.
- Frame length = (2 + DATA_W + PARITY_EN) × BIT_CYCLES cycles, measured from the accepting edge to the edge entering IDLE. Defaults: 7 cycles.
- done rises at the same edge that enters IDLE. ready=1 in that same cycle.
- Back-to-back: if load=1 during the done cycle, the new frame is accepted at the next edge. The minimum inter-frame gap is one idle cycle with sout=1.
- load and clr both high: reset wins and the word is not captured.
- BIT_CYCLES=1: every state except IDLE lasts one cycle, with no extra stall cycle.

## Test plan
- Reset defaults: hold clr=1 for 3 cycles with load=1 and A=4'b1111 → sout=1, ready=1, busy=0, done=0 throughout, and no frame starts.
- Basic frame, defaults: A=4'b0101 (A[0]=0), load pulsed 1 cycle → sout over the next 7 cycles = 0,0,1,0,1,0,1. Then done=1 for one cycle and ready=1.
- Parity and no-parity: A=4'b0111 with PARITY_EN=1 → parity bit = 1, frame 0,0,1,1,1,1,1. Same A with PARITY_EN=0 → 6-cycle frame 0,0,1,1,1,1.
- Stretching and ignored load: BIT_CYCLES=3, A=4'b1000 → each bit held 3 cycles, 21-cycle frame. A second load and a change of A at cycle 5 are ignored, and the frame content is unchanged.
- Back-to-back: load held high continuously with A=4'b1100, then 4'b0011 → two frames separated by exactly one sout=1 idle cycle, with done pulsing once per frame.
- Mid-frame reset: clr=1 for one cycle during the second data bit → sout=1, ready=1 on the next cycle, and no done pulse. A subsequent load of A=4'b1010 produces a clean frame 0,1,0,1,0,0,1.
